// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the 2-read/1-write register file:
// clear-engine state encoding and the byte-enable merge used by the write path and bypass.
package reg_file_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int unsigned MERGE_MAX_W  = 256;
    localparam int unsigned MERGE_MAX_BE = MERGE_MAX_W / 8;

    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]  old_word,
        input logic [MERGE_MAX_W-1:0]  new_word,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(MERGE_MAX_BE); i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_clr_ctrl.sv
// Bulk-clear sequencer: walks every address once after a clr pulse,
// presenting one clear strobe/address per cycle and holding busy while it runs.
module reg_file_clr_ctrl
    import reg_file_pkg::*;
#(
    parameter int unsigned AWIDTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              clr_stb_o,
    output logic [AWIDTH-1:0] clr_addr_o
);

    localparam logic [AWIDTH-1:0] CNT_LAST = {AWIDTH{1'b1}};

    clr_state_e        state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    // State, counter and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {AWIDTH{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; clr is ignored once the sweep has started.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {AWIDTH{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + AWIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {AWIDTH{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy_o     = busy_q;
    assign clr_stb_o  = (state_q == ST_CLEAR);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Flop-based register file: one byte-enabled write port, two registered read ports
// with write/clear bypass, and a sequenced bulk clear.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wren,
    input  logic [AWIDTH-1:0]   waddr,
    input  logic [DWIDTH-1:0]   wdata,
    input  logic [DWIDTH/8-1:0] wbe,
    input  logic                rden_a,
    input  logic                rden_b,
    input  logic [AWIDTH-1:0]   raddr_a,
    input  logic [AWIDTH-1:0]   raddr_b,
    output logic [DWIDTH-1:0]   rdata_a,
    output logic [DWIDTH-1:0]   rdata_b,
    output logic                rvalid_a,
    output logic                rvalid_b,
    input  logic                clr,
    output logic                busy
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] mem_d [DEPTH];
    logic [DWIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [DWIDTH-1:0] rdata_b_q, rdata_b_d;
    logic              rvalid_a_q, rvalid_b_q;

    logic              busy_s;
    logic              clr_stb_s;
    logic [AWIDTH-1:0] clr_addr_s;
    logic              wr_en_s;
    logic [DWIDTH-1:0] merged_s;

    reg_file_clr_ctrl #(
        .AWIDTH (AWIDTH)
    ) u_clr_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .busy_o     (busy_s),
        .clr_stb_o  (clr_stb_s),
        .clr_addr_o (clr_addr_s)
    );

    // A clr pulse in IDLE takes priority over a same-cycle write.
    assign wr_en_s  = wren & ~busy_s & ~clr;
    assign merged_s = DWIDTH'(byte_merge(MERGE_MAX_W'(mem_q[waddr]),
                                         MERGE_MAX_W'(wdata),
                                         MERGE_MAX_BE'(wbe)));

    // Next storage image; reads sample it, which provides write and clear bypass.
    always_comb begin
        mem_d = mem_q;
        if (clr_stb_s) begin
            mem_d[clr_addr_s] = {DWIDTH{1'b0}};
        end else if (wr_en_s) begin
            mem_d[waddr] = merged_s;
        end else begin
            mem_d = mem_q;
        end
    end

    // Read-data next values; data holds when the port is not requested.
    always_comb begin
        rdata_a_d = rden_a ? mem_d[raddr_a] : rdata_a_q;
        rdata_b_d = rden_b ? mem_d[raddr_b] : rdata_b_q;
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {DWIDTH{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Registered read ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_q  <= {DWIDTH{1'b0}};
            rdata_b_q  <= {DWIDTH{1'b0}};
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= rden_a;
            rvalid_b_q <= rden_b;
        end
    end

    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign busy     = busy_s;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w (DWIDTH=16, AWIDTH=2): directed vector table,
// hand-written clear/reset sequences, and random traffic against a behavioural model.
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wren = 1'b0;
    logic [1:0]  waddr = 2'd0;
    logic [15:0] wdata = 16'h0;
    logic [1:0]  wbe = 2'b00;
    logic        rden_a = 1'b0, rden_b = 1'b0;
    logic [1:0]  raddr_a = 2'd0, raddr_b = 2'd0;
    logic [15:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b;
    logic        clr = 1'b0;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // Behavioural model: memory contents, clear progress, expected read registers.
    logic [15:0] m_mem [4];
    bit          m_busy;
    int          m_next_clr;
    logic [15:0] m_ra, m_rb;
    bit          m_va, m_vb;

    typedef struct {
        logic        wren;
        logic [1:0]  waddr;
        logic [15:0] wdata;
        logic [1:0]  wbe;
        logic        rden_a;
        logic [1:0]  raddr_a;
        logic        rden_b;
        logic [1:0]  raddr_b;
        logic        clr;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [15:0] ea;
        logic        va;
        logic [15:0] eb;
        logic        vb;
        logic        eb_busy;
    } vec_t;

    reg_file_2r1w #(.DWIDTH(16), .AWIDTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wren     (wren),
        .waddr    (waddr),
        .wdata    (wdata),
        .wbe      (wbe),
        .rden_a   (rden_a),
        .rden_b   (rden_b),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .rvalid_a (rvalid_a),
        .rvalid_b (rvalid_b),
        .clr      (clr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                                 input logic [1:0] be, input logic ra_en, input logic [1:0] ra,
                                 input logic rb_en, input logic [1:0] rb, input logic c);
        stim_t s;
        s.wren = we; s.waddr = wa; s.wdata = wd; s.wbe = be;
        s.rden_a = ra_en; s.raddr_a = ra; s.rden_b = rb_en; s.raddr_b = rb; s.clr = c;
        return s;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_mem[i] = 16'h0;
        m_busy = 1'b0; m_next_clr = 0;
        m_ra = 16'h0; m_rb = 16'h0; m_va = 1'b0; m_vb = 1'b0;
    endtask

    // Apply one cycle of stimulus, advance the model, then compare after the edge.
    task automatic step(input stim_t s);
        logic [15:0] nm [4];
        wren = s.wren; waddr = s.waddr; wdata = s.wdata; wbe = s.wbe;
        rden_a = s.rden_a; raddr_a = s.raddr_a; rden_b = s.rden_b; raddr_b = s.raddr_b;
        clr = s.clr;
        for (int i = 0; i < 4; i++) nm[i] = m_mem[i];
        if (m_busy) begin
            nm[m_next_clr] = 16'h0;
            m_next_clr++;
            if (m_next_clr == 4) m_busy = 1'b0;
        end else if (s.clr) begin
            m_busy = 1'b1; m_next_clr = 0;
        end else if (s.wren) begin
            for (int b = 0; b < 2; b++)
                if (s.wbe[b]) nm[s.waddr][8*b +: 8] = s.wdata[8*b +: 8];
        end
        if (s.rden_a) m_ra = nm[s.raddr_a];
        if (s.rden_b) m_rb = nm[s.raddr_b];
        m_va = s.rden_a; m_vb = s.rden_b;
        for (int i = 0; i < 4; i++) m_mem[i] = nm[i];
        @(posedge clk);
        #1;
        check("model_rdata_a", rdata_a, m_ra);
        check("model_rdata_b", rdata_b, m_rb);
        check("model_rvalid_a", 16'(rvalid_a), 16'(m_va));
        check("model_rvalid_b", 16'(rvalid_b), 16'(m_vb));
        check("model_busy", 16'(busy), 16'(m_busy));
    endtask

    stim_t nop;
    vec_t  vt [10];
    int    bcnt;

    initial begin
        model_reset();
        nop = mk(1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);

        // Power-on reset, then an asynchronous mid-cycle reset with live data.
        #12 rst_n = 1'b1;
        #1;
        check("por_rdata_a", rdata_a, 16'h0);
        check("por_busy", 16'(busy), 16'h0);
        step(mk(1'b1, 2'd0, 16'h1111, 2'b11, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0));
        step(mk(1'b0, 2'd0, 16'h0, 2'b00, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0));
        check("pre_rst_rdata_a", rdata_a, 16'h1111);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_rdata_a", rdata_a, 16'h0);
        check("async_rst_rdata_b", rdata_b, 16'h0);
        check("async_rst_rvalid_a", 16'(rvalid_a), 16'h0);
        check("async_rst_busy", 16'(busy), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(mk(1'b0, 2'd0, 16'h0, 2'b00, 1'b1, 2'(i), 1'b0, 2'd0, 1'b0));
            check("post_rst_entry", rdata_a, 16'h0);
        end

        // Directed vectors from the all-zero state.
        vt[0] = '{mk(1'b1, 2'd1, 16'hABCD, 2'b11, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0), 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vt[1] = '{mk(1'b1, 2'd1, 16'h1234, 2'b01, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0), 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vt[2] = '{mk(1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0), 16'hAB34, 1'b1, 16'h0000, 1'b0, 1'b0};
        vt[3] = '{mk(1'b1, 2'd2, 16'h0055, 2'b11, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0), 16'hAB34, 1'b0, 16'hAB34, 1'b1, 1'b0};
        vt[4] = '{mk(1'b1, 2'd3, 16'h0077, 2'b11, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0), 16'hAB34, 1'b0, 16'hAB34, 1'b0, 1'b0};
        vt[5] = '{mk(1'b1, 2'd2, 16'h00AA, 2'b11, 1'b1, 2'd2, 1'b1, 2'd3, 1'b0), 16'h00AA, 1'b1, 16'h0077, 1'b1, 1'b0};
        vt[6] = '{nop,                                                            16'h00AA, 1'b0, 16'h0077, 1'b0, 1'b0};
        vt[7] = '{mk(1'b1, 2'd0, 16'hFFFF, 2'b00, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0), 16'h0000, 1'b1, 16'h0077, 1'b0, 1'b0};
        vt[8] = '{mk(1'b1, 2'd0, 16'hFFFF, 2'b10, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0), 16'h0000, 1'b0, 16'hFF00, 1'b1, 1'b0};
        vt[9] = '{mk(1'b0, 2'd0, 16'h0000, 2'b00, 1'b1, 2'd2, 1'b1, 2'd1, 1'b0), 16'h00AA, 1'b1, 16'hAB34, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step(vt[i].s);
            check("vec_rdata_a", rdata_a, vt[i].ea);
            check("vec_rvalid_a", 16'(rvalid_a), 16'(vt[i].va));
            check("vec_rdata_b", rdata_b, vt[i].eb);
            check("vec_rvalid_b", 16'(rvalid_b), 16'(vt[i].vb));
            check("vec_busy", 16'(busy), 16'(vt[i].eb_busy));
        end

        // Clear: fill, pulse clr, write and re-clr during busy, count busy cycles.
        for (int i = 0; i < 4; i++)
            step(mk(1'b1, 2'(i), 16'(8'h11 * (i + 1)), 2'b11, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0));
        step(mk(1'b0, 2'd0, 16'h0, 2'b00, 1'b1, 2'd3, 1'b0, 2'd0, 1'b1));
        check("clr_start_read", rdata_a, 16'h0044);
        bcnt = busy ? 1 : 0;
        for (int i = 0; i < 20 && busy; i++) begin
            step(mk(1'b1, 2'd0, 16'h9999, 2'b11, 1'b1, 2'(i), 1'b1, 2'd3, (i == 1) ? 1'b1 : 1'b0));
            if (busy) bcnt++;
        end
        check("clr_busy_cycles", 16'(bcnt), 16'd4);
        for (int i = 0; i < 4; i++) begin
            step(mk(1'b0, 2'd0, 16'h0, 2'b00, 1'b1, 2'(i), 1'b1, 2'(3 - i), 1'b0));
            check("post_clr_a", rdata_a, 16'h0);
            check("post_clr_b", rdata_b, 16'h0);
        end

        // clr and wren in the same IDLE cycle: write dropped, entry 1 keeps old data.
        step(mk(1'b1, 2'd1, 16'h0123, 2'b11, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0));
        step(mk(1'b1, 2'd1, 16'h5A5A, 2'b11, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1));
        check("clr_wr_collide_bypass", rdata_a, 16'h0123);
        step(mk(1'b0, 2'd0, 16'h0, 2'b00, 1'b1, 2'd1, 1'b1, 2'd0, 1'b0));
        check("clr_wr_collide_stored", rdata_a, 16'h0123);
        check("clr_bypass_entry0", rdata_b, 16'h0);
        for (int i = 0; i < 4; i++) step(nop);
        check("clr_collide_done", 16'(busy), 16'h0);

        // Reset during the second cycle of a clear.
        step(mk(1'b1, 2'd3, 16'hBEEF, 2'b11, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0));
        step(mk(1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1));
        step(nop);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_clr_rst_busy", 16'(busy), 16'h0);
        check("mid_clr_rst_rvalid", 16'(rvalid_a), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(mk(1'b0, 2'd0, 16'h0, 2'b00, 1'b1, 2'(i), 1'b0, 2'd0, 1'b0));
            check("mid_clr_rst_entry", rdata_a, 16'h0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(mk(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom), 2'($urandom),
                    1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom_range(0, 1)), 2'($urandom),
                    ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
